prio_index_decoder: RTL and testbench

PRIO_INDEX_DECODER -- requirements
Module: prio_index_decoder

---
 rtl/prio_pkg.sv | 13 +
 rtl/idx_expand.sv | 20 ++
 rtl/prio_index_decoder.sv | 64 ++++++
 tb/tb_prio_index_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the priority encoder/decoder pair: vector width,
// index width and the op encodings.
package prio_pkg;
  localparam int N = 128;
  localparam int W = 7;

  typedef enum logic [1:0] {
    OP_DEC   = 2'b00,
    OP_THERM = 2'b01,
    OP_SET   = 2'b10,
    OP_EMIT  = 2'b11
  } op_e;
endpackage

// File: rtl/idx_expand.sv
// Combinational expansion of an encoded index into one-hot and thermometer
// vectors. Indices past the vector width give no one-hot bit and a full thermometer.
module idx_expand #(
  parameter int N = prio_pkg::N,
  parameter int W = prio_pkg::W
) (
  input  logic [W-1:0] idx,
  input  logic         any,
  output logic [N-1:0] onehot,
  output logic [N-1:0] therm
);
  always_comb begin
    onehot = '0;
    therm  = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = any && (int'(idx) == i);
      therm[i]  = any && (int'(idx) >= i);
    end
  end
endmodule

// File: rtl/prio_index_decoder.sv
// Decodes priority indices into one-hot/thermometer vectors and collects SET
// bits into an accumulator that EMIT drains, behind a one-deep output register.
module prio_index_decoder
  import prio_pkg::*;
#(
  parameter int N = prio_pkg::N,
  parameter int W = prio_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_idx,
  input  logic         in_any,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_vec,
  output logic         acc_nz
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state;
  op_e         op;
  logic [N-1:0] acc, onehot, therm;
  logic        accept, produce, xfer;

  idx_expand #(.N(N), .W(W)) u_expand (
    .idx    (in_idx),
    .any    (in_any),
    .onehot (onehot),
    .therm  (therm)
  );

  assign op        = op_e'(in_op);
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign produce   = accept && (op != OP_SET);
  assign xfer      = out_valid && out_ready;
  assign acc_nz    = |acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      out_vec <= '0;
      acc     <= '0;
    end else begin
      // A producing beat reloads the register even while the old beat drains.
      if (produce) begin
        state <= FULL;
        case (op)
          OP_DEC:   out_vec <= onehot;
          OP_THERM: out_vec <= therm;
          default:  out_vec <= acc;
        endcase
      end else if (xfer) begin
        state <= EMPTY;
      end
      if (accept && op == OP_SET)       acc <= acc | onehot;
      else if (accept && op == OP_EMIT) acc <= '0;
    end
  end
endmodule

// File: tb/tb_prio_index_decoder.sv
// Directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_prio_index_decoder;
  import prio_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_idx;
  logic         in_any;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_vec;
  logic         acc_nz;

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  logic         m_valid;
  logic [N-1:0] m_vec;
  logic [N-1:0] m_acc;

  prio_index_decoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_any    (in_any),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .acc_nz    (acc_nz)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] dec_vec(int idx, logic any);
    logic [N-1:0] v;
    v = '0;
    v[0] = 1'b1;
    return any ? (v << idx) : '0;
  endfunction

  // Bits [idx:0] set: (1 << (idx+1)) - 1, which is all ones for idx >= N.
  function automatic logic [N-1:0] therm_vec(int idx, logic any);
    logic [N:0] t;
    if (!any) return '0;
    t = '0;
    t[0] = 1'b1;
    t = (t << (idx + 1)) - 1'b1;
    return t[N-1:0];
  endfunction

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level view of the block.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_vec   <= '0;
      m_acc   <= '0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      case (in_op)
        OP_DEC:   begin m_valid <= 1'b1; m_vec <= dec_vec(int'(in_idx), in_any); end
        OP_THERM: begin m_valid <= 1'b1; m_vec <= therm_vec(int'(in_idx), in_any); end
        OP_SET:   begin
          m_acc <= m_acc | dec_vec(int'(in_idx), in_any);
          if (out_ready) m_valid <= 1'b0;
        end
        default:  begin m_valid <= 1'b1; m_vec <= m_acc; m_acc <= '0; end
      endcase
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", N'(in_ready), N'(!m_valid || out_ready));
      chk("out_valid", N'(out_valid), N'(m_valid));
      chk("acc_nz", N'(acc_nz), N'(|m_acc));
      if (m_valid) chk("out_vec", out_vec, m_vec);
    end
  end

  task automatic beat(logic v, logic [1:0] op, int idx, logic any, logic rdy);
    in_valid  = v;
    in_op     = op;
    in_idx    = W'(idx);
    in_any    = any;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp;
    rst = 1'b1; in_valid = 0; in_op = 0; in_idx = 0; in_any = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", N'(out_valid), '0);
    chk("reset out_vec", out_vec, '0);
    chk("reset acc_nz", N'(acc_nz), '0);
    rst = 1'b0;
    armed = 1;

    // DEC
    beat(1, OP_DEC, 5, 1, 1);
    chk("s1 valid", N'(out_valid), N'(1));
    exp = '0; exp[5] = 1'b1;
    chk("s1 vec", out_vec, exp);
    beat(0, OP_DEC, 0, 0, 1);
    chk("s1 drain", N'(out_valid), '0);

    // THERM
    beat(1, OP_THERM, 127, 1, 1);
    chk("s2 therm127", out_vec, '1);
    beat(1, OP_THERM, 0, 1, 1);
    chk("s2 therm0", out_vec, N'(1));
    beat(1, OP_THERM, 77, 0, 1);
    chk("s2 any0", out_vec, '0);
    beat(0, OP_DEC, 0, 0, 1);

    // accumulate
    beat(1, OP_SET, 3, 1, 1);
    beat(1, OP_SET, 100, 1, 1);
    beat(1, OP_SET, 3, 1, 1);
    chk("s3 nz before", N'(acc_nz), N'(1));
    chk("s3 no beat", N'(out_valid), '0);
    beat(1, OP_EMIT, 0, 0, 1);
    exp = '0; exp[3] = 1'b1; exp[100] = 1'b1;
    chk("s3 emit", out_vec, exp);
    chk("s3 nz after", N'(acc_nz), '0);
    beat(0, OP_DEC, 0, 0, 1);

    // backpressure
    beat(1, OP_DEC, 9, 1, 0);
    exp = '0; exp[9] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_idx = W'(10);
      #1;
      chk("s4 in_ready", N'(in_ready), '0);
      beat(1, OP_DEC, 10, 1, 0);
      chk("s4 hold", out_vec, exp);
    end
    beat(0, OP_DEC, 0, 0, 1);
    chk("s4 transfer", N'(out_valid), '0);
    beat(1, OP_DEC, 10, 1, 1);
    exp = '0; exp[10] = 1'b1;
    chk("s4 next", out_vec, exp);

    // throughput
    for (int i = 0; i < 8; i++) begin
      beat(1, OP_DEC, i, 1, 1);
      exp = '0; exp[i] = 1'b1;
      chk("s5 valid", N'(out_valid), N'(1));
      chk("s5 vec", out_vec, exp);
    end
    beat(0, OP_DEC, 0, 0, 1);

    // reset mid-stream
    beat(1, OP_SET, 42, 1, 1);
    beat(1, OP_DEC, 1, 1, 0);
    rst = 1'b1;
    beat(1, OP_EMIT, 0, 0, 0);
    rst = 1'b0;
    chk("s6 valid", N'(out_valid), '0);
    chk("s6 nz", N'(acc_nz), '0);
    beat(1, OP_EMIT, 0, 0, 1);
    chk("s6 emit", out_vec, '0);
    chk("s6 emit valid", N'(out_valid), N'(1));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      beat($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
           int'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) < 6);
    end
    rst = 1'b0;
    beat(0, OP_DEC, 0, 0, 1);
    @(negedge clk);
    armed = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
